row_feeder: RTL
===============

// Module: row_feeder
// PURPOSE
//  Producer side of the per-row renderer interface. Takes one trace result per
//  screen row from the tracer over a valid/ready handshake and buffers it in a
//  pending slot, promoting it to an active slot at each row_start. Drives the
//  active wall/side/size/texu and a stepped texture 'v' coordinate (texv) to the
//  row renderer, one update per pixel clock.
// PARAMETERS
//  H_VIEW   640  visible pixels per row; HALF = H_VIEW/2 is the span centre
//  STEP_W   16   width of vstart/vstep/accumulator, Q6.(STEP_W-6) fixed point
// PORTS
//  clk          in   1       pixel clock; hpos advances once per clk
//  reset_n      in   1       asynchronous, active-low reset
//  in_valid     in   1       tracer presents a result
//  in_ready     out  1       block can accept a result (= pending slot empty)
//  in_wall      in   2       wall texture ID
//  in_side      in   1       1 = light side
//  in_size      in   11      wall half-height in pixels, 0..2047
//  in_texu      in   6       texture u, 0..63
//  in_vstart    in   STEP_W  texv accumulator value at span start (Q6.f)
//  in_vstep     in   STEP_W  texv increment per pixel inside span (Q6.f)
//  row_start    in   1       1-cycle pulse in horizontal blanking, before hpos=0
//  hpos         in   10      current pixel position in row
//  wall         out  2       active wall ID
//  side         out  1       active side
//  size         out  11      active size
//  texu         out  6       active texu
//  texv         out  6       acc[STEP_W-1:STEP_W-6]
//  row_valid    out  1       active slot holds at least one loaded result
//  underrun     out  1       1-cycle pulse: row_start with pending slot empty
//  underrun_cnt out  8       saturating count of underruns
// BEHAVIOUR
//  Reset (async, reset_n=0): pending empty, in_ready=1, wall/side/size/texu=0,
//   acc=0 (texv=0), row_valid=0, underrun=0, underrun_cnt=0. Any in-flight
//   handshake is dropped; nothing accepted during reset.
//  Accept: in_valid & in_ready at a rising edge -> all in_* latched into
//   pending; pending full next cycle; in_ready combinational = !pending_full.
//  Promote: row_start with pending full -> at that edge pending copied to
//   active, acc <= pending vstart, pending emptied, row_valid <= 1.
//  row_start + in_valid same cycle with pending full: promote only; in_ready
//   was 0, so no accept; accept possible from next cycle.
//  row_start with pending empty: active fields and vstep kept (previous row
//   repeated), acc <= stored vstart, underrun pulses 1 cycle, underrun_cnt
//   increments, saturating at 255. row_valid unchanged.
//  Span: in_span = (size > HALF) | ((HALF-size <= hpos) & (hpos <= HALF+size)),
//   compared at 12 bits with no wrap (HALF-size < 0 -> span starts at hpos 0).
//  Stepping: each edge with !row_start & in_span & row_valid: acc <= acc+vstep,
//   mod 2^STEP_W (texv wraps 63->0). Outside span acc holds.
//  Latency: texv seen with hpos=h is acc before the edge at h; first span pixel
//   shows vstart integer part; accept-to-output is >=1 row_start.
//  row_start has priority over stepping in the same cycle.
//  All outputs except in_ready are registered.
// TESTING
//  1 Reset then assert: in_ready=1, row_valid=0, texv=0, underrun_cnt=0.
//  2 Accept wall=2,side=1,size=100,texu=17,vstart=0,vstep=0x0140 (Q6.10 0.3125);
//    row_start -> wall=2,size=100,texu=17; texv=0 at hpos=220, =31 at hpos=320.
//  3 row_start with no pending: underrun 1 cycle, cnt=1, previous row outputs
//    repeated; 300 such rows -> cnt=255.
//  4 in_valid held, pending full, row_start: in_ready low that cycle, new item
//    accepted next cycle, exactly one promotion, no item lost or duplicated.
//  5 size=400 (>HALF), vstart=0x2000, vstep=0x0040: texv=8 at hpos=0, wraps to
//    0 after 896 steps (hpos 0..639 stays in span).
//  6 reset_n low mid-row with pending full: all outputs to reset values
//    immediately, in_ready=1, texv=0.

Source files
------------

// File: rtl/row_feeder.sv
// Row feeder: buffers one tracer result per screen row and drives the active
// wall/side/size/texu plus a stepped texture v coordinate to the row renderer.
//
// state      | meaning
// SLOT_EMPTY | pending slot free, in_ready high, row_start repeats the last row
// SLOT_FULL  | pending slot holds a result waiting for the next row_start

module row_feeder #(
  parameter int H_VIEW = 640,
  parameter int STEP_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_wall,
  input  logic              in_side,
  input  logic [10:0]       in_size,
  input  logic [5:0]        in_texu,
  input  logic [STEP_W-1:0] in_vstart,
  input  logic [STEP_W-1:0] in_vstep,
  input  logic              row_start,
  input  logic [9:0]        hpos,
  output logic [1:0]        wall,
  output logic              side,
  output logic [10:0]       size,
  output logic [5:0]        texu,
  output logic [5:0]        texv,
  output logic              row_valid,
  output logic              underrun,
  output logic [7:0]        underrun_cnt
);

  localparam logic [11:0] HALF = 12'(H_VIEW / 2);

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_t;

  slot_t slot_q, slot_d;

  logic              accept;
  logic              promote;
  logic              repeat_row;
  logic              in_span;

  logic [1:0]        p_wall;
  logic              p_side;
  logic [10:0]       p_size;
  logic [5:0]        p_texu;
  logic [STEP_W-1:0] p_vstart;
  logic [STEP_W-1:0] p_vstep;

  logic [STEP_W-1:0] a_vstart;
  logic [STEP_W-1:0] a_vstep;
  logic [STEP_W-1:0] acc;

  logic [11:0]       size_w;
  logic [11:0]       hpos_w;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) slot_q <= SLOT_EMPTY;
    else          slot_q <= slot_d;
  end

  // An empty slot can accept in the same cycle as a repeat-row row_start;
  // a full slot never accepts, so promote and accept never collide.
  always_comb begin
    slot_d     = slot_q;
    accept     = 1'b0;
    promote    = 1'b0;
    repeat_row = 1'b0;
    case (slot_q)
      SLOT_EMPTY: begin
        if (row_start) repeat_row = 1'b1;
        if (in_valid) begin
          accept = 1'b1;
          slot_d = SLOT_FULL;
        end
      end
      SLOT_FULL: begin
        if (row_start) begin
          promote = 1'b1;
          slot_d  = SLOT_EMPTY;
        end
      end
      default: slot_d = SLOT_EMPTY;
    endcase
  end

  assign in_ready = (slot_q == SLOT_EMPTY);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p_wall   <= '0;
      p_side   <= 1'b0;
      p_size   <= '0;
      p_texu   <= '0;
      p_vstart <= '0;
      p_vstep  <= '0;
    end else if (accept) begin
      p_wall   <= in_wall;
      p_side   <= in_side;
      p_size   <= in_size;
      p_texu   <= in_texu;
      p_vstart <= in_vstart;
      p_vstep  <= in_vstep;
    end
  end

  // 12-bit compare without subtraction: hpos + size >= HALF is the same as
  // HALF - size <= hpos but cannot go negative for large sizes.
  assign size_w  = {1'b0, size};
  assign hpos_w  = {2'b0, hpos};
  assign in_span = (size_w > HALF) |
                   (((hpos_w + size_w) >= HALF) & (hpos_w <= (HALF + size_w)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wall      <= '0;
      side      <= 1'b0;
      size      <= '0;
      texu      <= '0;
      a_vstart  <= '0;
      a_vstep   <= '0;
      row_valid <= 1'b0;
    end else if (promote) begin
      wall      <= p_wall;
      side      <= p_side;
      size      <= p_size;
      texu      <= p_texu;
      a_vstart  <= p_vstart;
      a_vstep   <= p_vstep;
      row_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
    end else if (promote) begin
      acc <= p_vstart;
    end else if (repeat_row) begin
      acc <= a_vstart;
    end else if (in_span && row_valid) begin
      acc <= acc + a_vstep;
    end
  end

  assign texv = acc[STEP_W-1 -: 6];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      underrun <= repeat_row;
      if (repeat_row && (underrun_cnt != 8'hFF)) underrun_cnt <= underrun_cnt + 8'd1;
    end
  end

endmodule
